// File: rtl/aes128_enc_iter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes128_enc_iter_if                                                       |
// | Block-in / ciphertext-out handshake bundle for the AES-128 encryptor.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface aes128_enc_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] key_in;
    logic [127:0] pt_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ct_out;

    modport master (
        output in_valid, key_in, pt_in, out_ready,
        input  in_ready, out_valid, ct_out
    );

    modport slave (
        input  in_valid, key_in, pt_in, out_ready,
        output in_ready, out_valid, ct_out
    );
endinterface
`default_nettype wire

// File: rtl/aes128_enc_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes128_enc_iter                                                          |
// | Iterative AES-128 encryptor, one round per clock, on-the-fly key         |
// | expansion. Define AES_ENC_LAST_KEY_OUT_EN to export the round-10 key.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module aes128_enc_iter #(
    parameter int NR = 10
) (
    input  wire logic     clk,
    input  wire logic     rst,
`ifdef AES_ENC_LAST_KEY_OUT_EN
    output logic [127:0]  last_key_out,
`endif
    aes128_enc_iter_if.slave bus
);

    generate
        if (NR != 10) begin : g_bad_nr
            $error("aes128_enc_iter: NR must be 10 for AES-128");
        end
    endgenerate

    localparam logic [3:0] c_LAST_ROUND = 4'(NR);

    localparam logic [0:255][7:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return c_SBOX[x];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    // Byte n lives at bits [127-8n -: 8]; row r of column c is byte 4c+r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rcon);
        logic [31:0] w0, w1, w2, w3, t;
        logic [31:0] n0, n1, n2, n3;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rcon, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_t       r_fsm;
    state_t       w_fsm_next;
    logic         w_in_ready;
    logic         w_out_valid;
    logic         w_accept;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [3:0]   r_round;
    logic [7:0]   r_rcon;
    logic [127:0] w_key_next;
    logic [127:0] w_sr;
    logic [127:0] w_state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next  = r_fsm;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_fsm_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_round == c_LAST_ROUND) begin
                    w_fsm_next = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_fsm_next = S_IDLE;
                end
            end
            default: w_fsm_next = S_IDLE;
        endcase
    end

    // Final round skips MixColumns.
    always_comb begin
        w_key_next   = key_step(r_key, r_rcon);
        w_sr         = shift_rows(sub_bytes(r_state));
        w_state_next = ((r_round == c_LAST_ROUND) ? w_sr : mix_columns(w_sr)) ^ w_key_next;
    end

    assign w_accept = (r_fsm == S_IDLE) && bus.in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= '0;
            r_key   <= '0;
            r_round <= '0;
            r_rcon  <= '0;
        end else if (w_accept) begin
            r_state <= bus.pt_in ^ bus.key_in;
            r_key   <= bus.key_in;
            r_round <= 4'd1;
            r_rcon  <= 8'h01;
        end else if (r_fsm == S_RUN) begin
            r_state <= w_state_next;
            r_key   <= w_key_next;
            r_rcon  <= xtime(r_rcon);
            r_round <= r_round + 4'd1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.ct_out    = r_state;

`ifdef AES_ENC_LAST_KEY_OUT_EN
    assign last_key_out = r_key;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes128_enc_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_aes128_enc_iter                                                       |
// | Directed known-answer bench for aes128_enc_iter.                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_aes128_enc_iter;

    localparam logic [127:0] c_KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_LK_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_LK_C  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    aes128_enc_iter_if bus ();

`ifdef AES_ENC_LAST_KEY_OUT_EN
    logic [127:0] last_key_out;
`endif

    aes128_enc_iter #(.NR(10)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef AES_ENC_LAST_KEY_OUT_EN
        .last_key_out (last_key_out),
`endif
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer one block at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [127:0] key, input logic [127:0] pt);
        bus.key_in   = key;
        bus.pt_in    = pt;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Clocks until out_valid is seen; lat = edges since accept, 0 on timeout.
    task automatic wait_out(output int lat);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.key_in    = '0;
        bus.pt_in     = '0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        n_checks++;
        if (bus.ct_out !== 128'h0) begin
            n_fail++; $display("FAIL reset_ct_out: got %h want 0", bus.ct_out);
        end
`ifdef AES_ENC_LAST_KEY_OUT_EN
        n_checks++;
        if (last_key_out !== 128'h0) begin
            n_fail++; $display("FAIL reset_last_key: got %h want 0", last_key_out);
        end
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_fips_b();
        int lat;
        bus.out_ready = 1'b1;
        send(c_KEY_B, c_PT_B);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL b_busy_in_ready: got %b want 0", bus.in_ready);
        end
        wait_out(lat);
        n_checks++;
        if (lat !== 10) begin
            n_fail++; $display("FAIL b_latency: got %0d want 10", lat);
        end
        n_checks++;
        if (bus.ct_out !== c_CT_B) begin
            n_fail++; $display("FAIL b_ct: got %h want %h", bus.ct_out, c_CT_B);
        end
`ifdef AES_ENC_LAST_KEY_OUT_EN
        n_checks++;
        if (last_key_out !== c_LK_B) begin
            n_fail++; $display("FAIL b_last_key: got %h want %h", last_key_out, c_LK_B);
        end
`endif
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b_one_cycle_pulse: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_fips_c1();
        int lat;
        bus.out_ready = 1'b1;
        send(c_KEY_C, c_PT_C);
        wait_out(lat);
        n_checks++;
        if (lat !== 10) begin
            n_fail++; $display("FAIL c1_latency: got %0d want 10", lat);
        end
        n_checks++;
        if (bus.ct_out !== c_CT_C) begin
            n_fail++; $display("FAIL c1_ct: got %h want %h", bus.ct_out, c_CT_C);
        end
`ifdef AES_ENC_LAST_KEY_OUT_EN
        n_checks++;
        if (last_key_out !== c_LK_C) begin
            n_fail++; $display("FAIL c1_last_key: got %h want %h", last_key_out, c_LK_C);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        bus.out_ready = 1'b0;
        send(c_KEY_C, c_PT_C);
        wait_out(lat);
        n_checks++;
        if (lat !== 10) begin
            n_fail++; $display("FAIL bp_latency: got %0d want 10", lat);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = i[0];
            bus.pt_in    = {$urandom, $urandom, $urandom, $urandom};
            bus.key_in   = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.ct_out !== c_CT_C) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b ct=%h want 1/0/%h",
                         i, bus.out_valid, bus.in_ready, bus.ct_out, c_CT_C);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int           acc_cyc [2];
        logic [127:0] ct_got  [2];
        int           n_acc;
        int           n_out;
        n_acc = 0;
        n_out = 0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        ct_got[0]  = '0;
        ct_got[1]  = '0;
        bus.key_in    = c_KEY_B;
        bus.pt_in     = c_PT_B;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1 && n_acc < 2) begin
                acc_cyc[n_acc] = i;
                n_acc++;
            end
            if (bus.out_valid === 1'b1 && n_out < 2) begin
                ct_got[n_out] = bus.ct_out;
                n_out++;
            end
            @(posedge clk);
            @(negedge clk);
            if (n_acc == 1) begin
                bus.key_in = c_KEY_C;
                bus.pt_in  = c_PT_C;
            end
            if (n_acc == 2) bus.in_valid = 1'b0;
        end
        n_checks++;
        if (n_acc !== 2 || n_out !== 2) begin
            n_fail++; $display("FAIL b2b_counts: accepts=%0d outputs=%0d want 2/2", n_acc, n_out);
        end
        n_checks++;
        if (acc_cyc[1] - acc_cyc[0] !== 12) begin
            n_fail++; $display("FAIL b2b_interval: got %0d want 12", acc_cyc[1] - acc_cyc[0]);
        end
        n_checks++;
        if (ct_got[0] !== c_CT_B) begin
            n_fail++; $display("FAIL b2b_ct0: got %h want %h", ct_got[0], c_CT_B);
        end
        n_checks++;
        if (ct_got[1] !== c_CT_C) begin
            n_fail++; $display("FAIL b2b_ct1: got %h want %h", ct_got[1], c_CT_C);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bus.out_ready = 1'b1;
        send(c_KEY_B, c_PT_B);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_reset: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
        end
        n_checks++;
        if (bus.ct_out !== 128'h0) begin
            n_fail++; $display("FAIL midrun_reset_ct: got %h want 0", bus.ct_out);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(c_KEY_C, c_PT_C);
        wait_out(lat);
        n_checks++;
        if (lat !== 10 || bus.ct_out !== c_CT_C) begin
            n_fail++;
            $display("FAIL midrun_recover: lat=%0d ct=%h want 10/%h", lat, bus.ct_out, c_CT_C);
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_fips_b();
        test_fips_c1();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
